// File: rtl/nebula_wb_arbiter.sv
// ============================================================================
// Module   : nebula_wb_arbiter
// Purpose  : Two-requester round-robin Wishbone master arbiter with timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nebula_wb_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_adr,
  input  logic [31:0] r0_dat,
  input  logic [3:0]  r0_sel,
  output logic [31:0] r0_rdata,
  output logic        r0_done,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_adr,
  input  logic [31:0] r1_dat,
  input  logic [3:0]  r1_sel,
  output logic [31:0] r1_rdata,
  output logic        r1_done,
  output logic        r1_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] c_TIMER_LIMIT = 8'(TIMEOUT - 1);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_gnt;
  logic       r_last;
  logic [7:0] r_timer;
  logic       r_cyc;

  logic       w_any_req;
  logic       w_gnt_req;
  logic       w_ack_hit;
  logic       w_timeout;
  logic       w_finish;
  logic       w_rd_cap;
  logic       w_grant;

  // Requester selection: with contention the one not served last wins.
  always_comb begin
    w_any_req = r0_req | r1_req;
    w_gnt_req = (r0_req & r1_req) ? ~r_last : r1_req;
    w_ack_hit = (r_state == S_BUS) & wbm_ack_i;
    w_timeout = (r_state == S_BUS) & ~wbm_ack_i & (r_timer == c_TIMER_LIMIT);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_BUS;
      S_BUS:   if (w_ack_hit | w_timeout) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant  = (r_state == S_IDLE) & w_any_req;
    w_finish = w_ack_hit | w_timeout;
    w_rd_cap = w_ack_hit & ~wbm_we_o;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_gnt     <= 1'b0;
      r_last    <= 1'b1;
      r_timer   <= 8'd0;
      r_cyc     <= 1'b0;
      busy      <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
      wbm_sel_o <= 4'd0;
      r0_rdata  <= 32'd0;
      r1_rdata  <= 32'd0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      r0_err    <= 1'b0;
      r1_err    <= 1'b0;
    end else begin
      r_cyc   <= (w_state_nxt == S_BUS);
      busy    <= (w_state_nxt != S_IDLE);
      r0_done <= w_finish & ~r_gnt;
      r1_done <= w_finish & r_gnt;
      r0_err  <= w_timeout & ~r_gnt;
      r1_err  <= w_timeout & r_gnt;
      if (w_grant) begin
        r_gnt     <= w_gnt_req;
        r_timer   <= 8'd0;
        wbm_we_o  <= w_gnt_req ? r1_we  : r0_we;
        wbm_adr_o <= w_gnt_req ? r1_adr : r0_adr;
        wbm_dat_o <= w_gnt_req ? r1_dat : r0_dat;
        wbm_sel_o <= w_gnt_req ? r1_sel : r0_sel;
      end else if ((r_state == S_BUS) && !w_finish) begin
        r_timer <= r_timer + 8'd1;
      end
      if (w_finish) begin
        r_last <= r_gnt;
      end
      if (w_rd_cap && !r_gnt) begin
        r0_rdata <= wbm_dat_i;
      end
      if (w_rd_cap && r_gnt) begin
        r1_rdata <= wbm_dat_i;
      end
    end
  end

  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;

endmodule

`default_nettype wire

// File: tb/tb_nebula_wb_arbiter.sv
// ============================================================================
// Module   : tb_nebula_wb_arbiter
// Purpose  : Directed self-checking bench for nebula_wb_arbiter (TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nebula_wb_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_adr, r0_dat, r1_adr, r1_dat;
  logic [3:0]  r0_sel, r1_sel;
  logic [31:0] r0_rdata, r1_rdata;
  logic        r0_done, r0_err, r1_done, r1_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy;

  logic        ack_drv;
  logic        zero_wait;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  // Zero-wait slave acknowledges every cycle that cyc is high.
  assign wbm_ack_i = zero_wait ? wbm_cyc_o : ack_drv;

  nebula_wb_arbiter #(.TIMEOUT(8)) u_dut (
    .clk(clk), .nrst(nrst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_adr(r0_adr), .r0_dat(r0_dat), .r0_sel(r0_sel),
    .r0_rdata(r0_rdata), .r0_done(r0_done), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_adr(r1_adr), .r1_dat(r1_dat), .r1_sel(r1_sel),
    .r1_rdata(r1_rdata), .r1_done(r1_done), .r1_err(r1_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0; ack_drv = 1'b0; zero_wait = 1'b0; wbm_dat_i = 32'd0;
    r0_req = 1'b0; r0_we = 1'b0; r0_adr = 32'd0; r0_dat = 32'd0; r0_sel = 4'd0;
    r1_req = 1'b0; r1_we = 1'b0; r1_adr = 32'd0; r1_dat = 32'd0; r1_sel = 4'd0;
    #2;
    chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_r0_rdata", r0_rdata, 32'd0);
    chk("rst_done", {30'd0, r0_done, r1_done}, 32'd0);
    tick(); tick();
    nrst = 1'b1;

    // Single read with two wait states
    r0_req = 1'b1; r0_we = 1'b0; r0_adr = 32'h3000_0010; r0_sel = 4'hF;
    tick();
    chk("rd_cyc1", {31'd0, wbm_cyc_o}, 32'd1);
    chk("rd_stb1", {31'd0, wbm_stb_o}, 32'd1);
    chk("rd_adr", wbm_adr_o, 32'h3000_0010);
    chk("rd_we", {31'd0, wbm_we_o}, 32'd0);
    chk("rd_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("rd_cyc2", {31'd0, wbm_cyc_o}, 32'd1);
    tick();
    chk("rd_cyc3", {31'd0, wbm_cyc_o}, 32'd1);
    chk("rd_nodone", {31'd0, r0_done}, 32'd0);
    ack_drv = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
    tick();
    chk("rd_cyc_off", {31'd0, wbm_cyc_o}, 32'd0);
    chk("rd_done", {31'd0, r0_done}, 32'd1);
    chk("rd_err", {31'd0, r0_err}, 32'd0);
    chk("rd_r1_done", {31'd0, r1_done}, 32'd0);
    chk("rd_rdata", r0_rdata, 32'hCAFE_F00D);
    chk("rd_busy_done", {31'd0, busy}, 32'd1);
    r0_req = 1'b0; ack_drv = 1'b0;
    tick();
    chk("rd_done_pulse", {31'd0, r0_done}, 32'd0);
    chk("rd_idle_busy", {31'd0, busy}, 32'd0);

    // Write by r1; inputs change mid-BUS and must not leak to the bus
    r1_req = 1'b1; r1_we = 1'b1; r1_adr = 32'h3000_0020; r1_dat = 32'h1234_5678; r1_sel = 4'b0011;
    tick();
    chk("wr_we", {31'd0, wbm_we_o}, 32'd1);
    chk("wr_adr", wbm_adr_o, 32'h3000_0020);
    chk("wr_dat", wbm_dat_o, 32'h1234_5678);
    chk("wr_sel", {28'd0, wbm_sel_o}, 32'h3);
    r1_adr = 32'hDEAD_BEEF; r1_dat = 32'h0; r1_sel = 4'hF; r1_we = 1'b0;
    tick();
    chk("wr_adr_hold", wbm_adr_o, 32'h3000_0020);
    chk("wr_dat_hold", wbm_dat_o, 32'h1234_5678);
    chk("wr_sel_hold", {28'd0, wbm_sel_o}, 32'h3);
    chk("wr_we_hold", {31'd0, wbm_we_o}, 32'd1);
    ack_drv = 1'b1; wbm_dat_i = 32'h5555_5555;
    tick();
    chk("wr_done", {31'd0, r1_done}, 32'd1);
    chk("wr_r0_done", {31'd0, r0_done}, 32'd0);
    chk("wr_r1_rdata", r1_rdata, 32'd0);
    chk("wr_r0_rdata", r0_rdata, 32'hCAFE_F00D);
    r1_req = 1'b0; ack_drv = 1'b0;
    tick();

    // Contention, zero-wait slave: r1 served last so r0 goes first
    zero_wait = 1'b1;
    r0_we = 1'b1; r0_adr = 32'h0000_00A0; r1_we = 1'b1; r1_adr = 32'h0000_00B0;
    r0_req = 1'b1; r1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ct%0d_adr", k), wbm_adr_o, (k % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B0);
      chk($sformatf("ct%0d_cyc", k), {31'd0, wbm_cyc_o}, 32'd1);
      tick();
      chk($sformatf("ct%0d_done", k), {30'd0, r1_done, r0_done}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("ct%0d_cyc_off", k), {31'd0, wbm_cyc_o}, 32'd0);
      if (k == 3) begin
        r0_req = 1'b0; r1_req = 1'b0;
      end
      tick();
      chk($sformatf("ct%0d_gap", k), {29'd0, wbm_cyc_o, r1_done, r0_done}, 32'd0);
    end
    zero_wait = 1'b0;
    tick();
    chk("ct_no_reissue", {31'd0, wbm_cyc_o}, 32'd0);

    // Timeout: cyc high for exactly 8 cycles, then done+err
    r0_req = 1'b1; r0_we = 1'b0; r0_adr = 32'h3000_0040;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_cyc%0d", i), {31'd0, wbm_cyc_o}, 32'd1);
      chk($sformatf("to_nodone%0d", i), {31'd0, r0_done}, 32'd0);
      tick();
    end
    chk("to_cyc_off", {31'd0, wbm_cyc_o}, 32'd0);
    chk("to_done", {31'd0, r0_done}, 32'd1);
    chk("to_err", {31'd0, r0_err}, 32'd1);
    chk("to_r1_err", {31'd0, r1_err}, 32'd0);
    chk("to_rdata", r0_rdata, 32'hCAFE_F00D);
    r0_req = 1'b0;
    tick();
    chk("to_err_pulse", {31'd0, r0_err}, 32'd0);

    // Ack arriving in BUS cycle TIMEOUT counts as success
    r0_req = 1'b1; r0_adr = 32'h3000_0050;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("lim_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    ack_drv = 1'b1; wbm_dat_i = 32'h0BAD_C0DE;
    tick();
    chk("lim_done", {31'd0, r0_done}, 32'd1);
    chk("lim_err", {31'd0, r0_err}, 32'd0);
    chk("lim_rdata", r0_rdata, 32'h0BAD_C0DE);
    r0_req = 1'b0; ack_drv = 1'b0;
    tick();

    // Asynchronous reset during BUS, then both requesting
    r1_req = 1'b1; r1_we = 1'b0; r1_adr = 32'h3000_0060;
    tick();
    chk("ar_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    chk("ar_adr", wbm_adr_o, 32'h3000_0060);
    #2;
    nrst = 1'b0;
    #1;
    chk("ar_cyc_async", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("ar_busy_async", {31'd0, busy}, 32'd0);
    chk("ar_pulses", {28'd0, r0_done, r0_err, r1_done, r1_err}, 32'd0);
    chk("ar_rdata", r0_rdata, 32'd0);
    tick();
    r0_req = 1'b1; r0_adr = 32'h3000_0070;
    nrst = 1'b1;
    tick();
    chk("ar_grant_r0", wbm_adr_o, 32'h3000_0070);
    ack_drv = 1'b1; wbm_dat_i = 32'h7777_7777;
    tick();
    chk("ar_r0_done", {30'd0, r1_done, r0_done}, 32'd1);
    r0_req = 1'b0; r1_req = 1'b0; ack_drv = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
